sd_ctrl: RTL and testbench

Programmable sequence-detection controller for the bit-serial detector path. Holds a run-time pattern configuration (pattern, length, overlap mode, match target), sequences arm/run/done phases, gates serial input bits with a valid qualifier, and counts detections. It replaces the fixed-pattern `SD` detector wherever software must change the pattern or stop after N hits.

---
 rtl/sd_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sd_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_ctrl.sv
// sd_ctrl: programmable serial sequence detector with arm/run/done sequencing,
// valid-qualified input, saturating match counter and optional stop-after-N.
module sd_ctrl #(
   parameter int unsigned MAXLEN = 8,
   parameter int unsigned CNTW   = 8
) (
   input  logic                      Clk,
   input  logic                      Rst_n,
   input  logic                      Cfg_we,
   input  logic [MAXLEN-1:0]         Cfg_pattern,
   input  logic [$clog2(MAXLEN):0]   Cfg_len,
   input  logic                      Cfg_overlap,
   input  logic [CNTW-1:0]           Cfg_target,
   input  logic                      Start,
   input  logic                      Abort,
   input  logic                      X,
   input  logic                      X_valid,
   output logic                      Y,
   output logic [CNTW-1:0]           Match_cnt,
   output logic                      Busy,
   output logic                      Done,
   output logic                      Cfg_err
);

   localparam int unsigned LW = $clog2(MAXLEN) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [MAXLEN-1:0] pat_q, pat_d;
   logic [LW-1:0]     len_q, len_d;
   logic              ovl_q, ovl_d;
   logic [CNTW-1:0]   tgt_q, tgt_d;
   logic              cfg_valid_q, cfg_valid_d;
   logic              cfg_err_q, cfg_err_d;
   logic [MAXLEN-1:0] hist_q, hist_d;
   logic [LW-1:0]     fill_q, fill_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              y_q, y_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [MAXLEN-1:0] len_mask;
   logic [MAXLEN-1:0] hist_nxt;
   logic [LW-1:0]     fill_nxt;
   logic [CNTW-1:0]   cnt_inc;
   logic              match;

   // Window mask selecting the low len bits of history/pattern
   always_comb begin
      len_mask = '0;
      for (int unsigned i = 0; i < MAXLEN; i++) begin
         len_mask[i] = (LW'(i) < len_q);
      end
   end

   // Candidate shift/fill/match values for a valid bit in RUN
   always_comb begin
      hist_nxt = MAXLEN'({hist_q, X});
      fill_nxt = (fill_q >= len_q) ? len_q : fill_q + LW'(1);
      match    = (fill_nxt == len_q) && (((hist_nxt ^ pat_q) & len_mask) == '0);
      cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNTW'(1);
   end

   // Next-state and registered-output decode
   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      len_d       = len_q;
      ovl_d       = ovl_q;
      tgt_d       = tgt_q;
      cfg_valid_d = cfg_valid_q;
      cfg_err_d   = cfg_err_q;
      hist_d      = hist_q;
      fill_d      = fill_q;
      cnt_d       = cnt_q;
      y_d         = 1'b0;
      busy_d      = busy_q;
      done_d      = done_q;

      if (state_q == ST_RUN) begin
         // Abort wins over any same-cycle match or target hit
         if (Abort) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end else if (X_valid) begin
            hist_d = hist_nxt;
            fill_d = fill_nxt;
            if (match) begin
               y_d   = 1'b1;
               cnt_d = cnt_inc;
               if (!ovl_q) begin
                  fill_d = '0;
               end
               if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
      end else begin
         // Config write is resolved before Start so Start sees its outcome
         if (Cfg_we) begin
            if ((Cfg_len == '0) || (Cfg_len > LW'(MAXLEN))) begin
               cfg_err_d   = 1'b1;
               cfg_valid_d = 1'b0;
            end else begin
               pat_d       = Cfg_pattern;
               len_d       = Cfg_len;
               ovl_d       = Cfg_overlap;
               tgt_d       = Cfg_target;
               cfg_err_d   = 1'b0;
               cfg_valid_d = 1'b1;
            end
         end
         if (Start && cfg_valid_d) begin
            state_d = ST_RUN;
            hist_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
         end
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q     <= ST_IDLE;
         pat_q       <= '0;
         len_q       <= '0;
         ovl_q       <= 1'b0;
         tgt_q       <= '0;
         cfg_valid_q <= 1'b0;
         cfg_err_q   <= 1'b0;
         hist_q      <= '0;
         fill_q      <= '0;
         cnt_q       <= '0;
         y_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         len_q       <= len_d;
         ovl_q       <= ovl_d;
         tgt_q       <= tgt_d;
         cfg_valid_q <= cfg_valid_d;
         cfg_err_q   <= cfg_err_d;
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         cnt_q       <= cnt_d;
         y_q         <= y_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign Y         = y_q;
   assign Match_cnt = cnt_q;
   assign Busy      = busy_q;
   assign Done      = done_q;
   assign Cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_sd_ctrl.sv
// Bench for sd_ctrl: directed plan steps plus random traffic, all checked
// against a bit-list reference model of the detector.
module tb_sd_ctrl;

   localparam int unsigned MAXLEN = 8;
   localparam int unsigned CNTW   = 8;
   localparam int unsigned LW     = $clog2(MAXLEN) + 1;

   logic              Clk = 1'b0;
   logic              Rst_n;
   logic              Cfg_we;
   logic [MAXLEN-1:0] Cfg_pattern;
   logic [LW-1:0]     Cfg_len;
   logic              Cfg_overlap;
   logic [CNTW-1:0]   Cfg_target;
   logic              Start;
   logic              Abort;
   logic              X;
   logic              X_valid;
   logic              Y;
   logic [CNTW-1:0]   Match_cnt;
   logic              Busy;
   logic              Done;
   logic              Cfg_err;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   bit              m_run, m_done, m_y, m_err, m_valid, m_ovl;
   int              m_cnt, m_len, m_tgt;
   bit [MAXLEN-1:0] m_pat;
   bit              seq[$];

   sd_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Cfg_we(Cfg_we), .Cfg_pattern(Cfg_pattern),
      .Cfg_len(Cfg_len), .Cfg_overlap(Cfg_overlap), .Cfg_target(Cfg_target),
      .Start(Start), .Abort(Abort), .X(X), .X_valid(X_valid), .Y(Y),
      .Match_cnt(Match_cnt), .Busy(Busy), .Done(Done), .Cfg_err(Cfg_err)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit tail_matches();
      if (seq.size() < m_len) return 1'b0;
      for (int k = 0; k < m_len; k++)
         if (seq[seq.size() - 1 - k] != m_pat[k]) return 1'b0;
      return 1'b1;
   endfunction

   // Model: what the outputs should read after the coming edge
   task automatic model_step();
      if (!Rst_n) begin
         m_run = 0; m_done = 0; m_y = 0; m_err = 0; m_valid = 0; m_ovl = 0;
         m_cnt = 0; m_len = 0; m_tgt = 0; m_pat = '0;
         seq.delete();
         return;
      end
      m_y = 0;
      if (!m_run) begin
         if (Cfg_we) begin
            if (Cfg_len == 0 || int'(Cfg_len) > MAXLEN) begin
               m_err = 1; m_valid = 0;
            end else begin
               m_pat = Cfg_pattern; m_len = int'(Cfg_len); m_ovl = Cfg_overlap;
               m_tgt = int'(Cfg_target); m_err = 0; m_valid = 1;
            end
         end
         if (Start && m_valid) begin
            seq.delete(); m_cnt = 0; m_done = 0; m_run = 1;
         end
      end else if (Abort) begin
         m_run = 0;
      end else if (X_valid) begin
         seq.push_back(X);
         if (seq.size() > MAXLEN) void'(seq.pop_front());
         if (tail_matches()) begin
            m_y = 1;
            if (m_cnt < (1 << CNTW) - 1) m_cnt++;
            if (!m_ovl) seq.delete();
            if (m_tgt != 0 && m_cnt == m_tgt) begin
               m_run = 0; m_done = 1;
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge Clk);
      #1;
      chk("Y", 32'(Y), 32'(m_y));
      chk("Match_cnt", 32'(Match_cnt), 32'(m_cnt));
      chk("Busy", 32'(Busy), 32'(m_run));
      chk("Done", 32'(Done), 32'(m_done));
      chk("Cfg_err", 32'(Cfg_err), 32'(m_err));
   endtask

   task automatic write_cfg(input logic [MAXLEN-1:0] pat, input int len,
                            input bit ovl, input int tgt);
      Cfg_we = 1; Cfg_pattern = pat; Cfg_len = LW'(len);
      Cfg_overlap = ovl; Cfg_target = CNTW'(tgt);
      tick();
      Cfg_we = 0;
   endtask

   task automatic start_run();
      Start = 1; tick(); Start = 0;
   endtask

   task automatic abort_run();
      Abort = 1; tick(); Abort = 0;
   endtask

   task automatic send_bit(input bit b);
      X = b; X_valid = 1; tick(); X_valid = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      Rst_n = 0; Cfg_we = 0; Cfg_pattern = '0; Cfg_len = '0; Cfg_overlap = 0;
      Cfg_target = '0; Start = 0; Abort = 0; X = 0; X_valid = 0;

      // Reset
      idle(2);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_cnt", 32'(Match_cnt), 32'd0);
      Rst_n = 1;
      idle(1);

      // Fixed-pattern equivalence: 110, non-overlap, free running
      write_cfg(8'b110, 3, 0, 0);
      start_run();
      send_bit(1); send_bit(1); send_bit(0);
      chk("fixed_y1", 32'(Y), 32'd1);
      idle(5);
      send_bit(1); send_bit(1); send_bit(0);
      chk("fixed_y2", 32'(Y), 32'd1);
      send_bit(1);
      chk("fixed_cnt", 32'(Match_cnt), 32'd2);
      chk("fixed_busy", 32'(Busy), 32'd1);
      abort_run();

      // Overlap on/off with 101 and stream 1,0,1,0,1
      write_cfg(8'b101, 3, 1, 0);
      start_run();
      send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
      chk("ovl1_cnt", 32'(Match_cnt), 32'd2);
      abort_run();
      write_cfg(8'b101, 3, 0, 0);
      start_run();
      send_bit(1); send_bit(0); send_bit(1); send_bit(0); send_bit(1);
      chk("ovl0_cnt", 32'(Match_cnt), 32'd1);
      abort_run();

      // Target stop at 2 matches
      write_cfg(8'b11, 2, 1, 2);
      start_run();
      send_bit(1); send_bit(1);
      chk("tgt_y_bit2", 32'(Y), 32'd1);
      send_bit(1);
      chk("tgt_y_bit3", 32'(Y), 32'd1);
      chk("tgt_done", 32'(Done), 32'd1);
      chk("tgt_busy", 32'(Busy), 32'd0);
      send_bit(1); send_bit(1);
      chk("tgt_cnt", 32'(Match_cnt), 32'd2);
      chk("tgt_done_hold", 32'(Done), 32'd1);

      // Config rules
      write_cfg(8'b01, 0, 0, 0);
      chk("cfg_err_set", 32'(Cfg_err), 32'd1);
      start_run();
      chk("cfg_start_blocked", 32'(Busy), 32'd0);
      write_cfg(8'b01, 2, 1, 0);
      chk("cfg_err_clr", 32'(Cfg_err), 32'd0);
      start_run();
      write_cfg(8'b10, 2, 1, 0);
      send_bit(0); send_bit(1);
      chk("cfg_run_ignored", 32'(Y), 32'd1);

      // Abort on the completing bit of a match
      send_bit(0);
      Abort = 1; send_bit(1); Abort = 0;
      chk("abort_y", 32'(Y), 32'd0);
      chk("abort_cnt", 32'(Match_cnt), 32'd1);
      chk("abort_busy", 32'(Busy), 32'd0);
      start_run();
      chk("restart_cnt", 32'(Match_cnt), 32'd0);

      // Reset mid-run after two matches
      send_bit(0); send_bit(1); send_bit(0); send_bit(1);
      chk("pre_rst_cnt", 32'(Match_cnt), 32'd2);
      Rst_n = 0; tick(); Rst_n = 1;
      chk("midrst_cnt", 32'(Match_cnt), 32'd0);
      chk("midrst_busy", 32'(Busy), 32'd0);
      start_run();
      chk("midrst_start_ign", 32'(Busy), 32'd0);
      write_cfg(8'b1, 1, 1, 0);
      start_run();
      chk("midrst_start_ok", 32'(Busy), 32'd1);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         Rst_n       = ($urandom_range(199) != 0);
         Cfg_we      = ($urandom_range(19) == 0);
         Cfg_pattern = MAXLEN'($urandom);
         Cfg_len     = ($urandom_range(9) == 0) ? LW'($urandom_range(15))
                                                : LW'($urandom_range(4, 1));
         Cfg_overlap = 1'($urandom_range(1));
         Cfg_target  = CNTW'($urandom_range(4));
         Start       = ($urandom_range(9) == 0);
         Abort       = ($urandom_range(39) == 0);
         X           = 1'($urandom_range(1));
         X_valid     = ($urandom_range(9) < 7);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
